io_in_ctrl: RTL and testbench

//  Parametrised multi-channel input-device controller for the processor I/O path.

---
 rtl/io_ctrl_pkg.sv | 23 ++
 rtl/io_sync_fifo.sv | 51 +++++
 rtl/io_in_ctrl.sv | 157 +++++++++++++++
 tb/tb_io_in_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_ctrl_pkg.sv
// Shared definitions for the multi-channel input controller:
// channel FSM states, the clog2 sizing helper and the default FIFO entry width.
package io_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_TOUT = 2'd2
    } chState_t;

    // Never returns less than 1 so that a 1-bit field always exists
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_CH = 4;
    localparam int ENT_W      = DEF_DATA_W + clog2(DEF_NUM_CH);

endpackage

// File: rtl/io_sync_fifo.sv
// Shared show-ahead FIFO for captured {channel, data} entries.
// Pointers carry an extra wrap bit so occupancy is simply their difference.
module io_sync_fifo
    import io_ctrl_pkg::*;
#(
    parameter int WIDTH = ENT_W,
    parameter int DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_clrN,
    input  logic                  i_wrEn,
    input  logic [WIDTH-1:0]      i_wrData,
    input  logic                  i_rdEn,
    output logic [WIDTH-1:0]      o_rdData,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [clog2(DEPTH):0] o_count
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             w_doWr;
    logic             w_doRd;

    assign o_count  = r_wrPtr - r_rdPtr;
    assign o_empty  = (o_count == '0);
    assign o_full   = (o_count == FULL_CNT);
    assign w_doWr   = i_wrEn && !o_full;
    assign w_doRd   = i_rdEn && !o_empty;
    assign o_rdData = r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_clrN) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doWr) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doRd) r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    // Storage needs no reset; the flushed pointers make stale contents invisible
    always_ff @(posedge i_clk) begin
        if (w_doWr) r_mem[r_wrPtr[AW-1:0]] <= i_wrData;
    end

endmodule

// File: rtl/io_in_ctrl.sv
// Multi-channel handshaked input controller: per-channel FSMs, round-robin capture into a tagged
// shared FIFO, maskable interrupts. Define IO_TIMEOUT_EN for ack timeouts and the to_err port.
module io_in_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4
`ifdef IO_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 15
`endif
) (
    input  logic                       g_clk,
    input  logic                       g_clr,
    input  logic [NUM_CH-1:0]          in_dev_hs,
    input  logic [NUM_CH*DATA_W-1:0]   input_bus,
    output logic [NUM_CH-1:0]          in_dev_ack,
    input  logic                       cpu_rd,
    output logic [DATA_W-1:0]          cpu_data,
    output logic [clog2(NUM_CH)-1:0]   cpu_ch,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic [clog2(FIFO_DEPTH):0] fifo_count,
    input  logic                       mask_wr,
    input  logic [NUM_CH-1:0]          mask_in,
    input  logic [NUM_CH-1:0]          itr_clr,
    output logic [NUM_CH-1:0]          mask_reg,
    output logic [NUM_CH-1:0]          itr_reg,
    output logic                       itr_pend
`ifdef IO_TIMEOUT_EN
    ,
    output logic [NUM_CH-1:0]          to_err
`endif
);

    localparam int CH_W    = clog2(NUM_CH);
    localparam int ENTRY_W = DATA_W + CH_W;
`ifdef IO_TIMEOUT_EN
    localparam int TO_W = clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
`endif

    logic [NUM_CH-1:0]  w_req;
    logic [NUM_CH-1:0]  w_grantVec;
    logic [CH_W-1:0]    w_grantIdx;
    logic               w_grantAny;
    logic               w_grant;
    logic [CH_W-1:0]    r_rrPtr;
    logic [ENTRY_W-1:0] w_wrEntry;
    logic [ENTRY_W-1:0] w_headEntry;

    // Search starts just after the last grantee so every requester is served in turn
    always_comb begin
        int idx;
        logic [CH_W-1:0] candIdx;
        idx        = 0;
        candIdx    = '0;
        w_grantAny = 1'b0;
        w_grantIdx = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            idx = int'(r_rrPtr) + off;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            candIdx = CH_W'(idx);
            if (!w_grantAny && w_req[candIdx]) begin
                w_grantAny = 1'b1;
                w_grantIdx = candIdx;
            end
        end
    end

    assign w_grant    = w_grantAny && !fifo_full;
    assign w_grantVec = w_grant ? (NUM_CH'(1) << w_grantIdx) : '0;
    assign w_wrEntry  = {w_grantIdx, input_bus[w_grantIdx*DATA_W +: DATA_W]};

    io_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (g_clk),
        .i_clrN   (g_clr),
        .i_wrEn   (w_grant),
        .i_wrData (w_wrEntry),
        .i_rdEn   (cpu_rd),
        .o_rdData (w_headEntry),
        .o_empty  (fifo_empty),
        .o_full   (fifo_full),
        .o_count  (fifo_count)
    );

    assign cpu_data = w_headEntry[DATA_W-1:0];
    assign cpu_ch   = w_headEntry[ENTRY_W-1:DATA_W];
    assign itr_pend = |(itr_reg & mask_reg);

    // A capture sets its pending bit even if the CPU clears that bit in the same cycle
    always_ff @(posedge g_clk) begin
        if (!g_clr) begin
            r_rrPtr  <= '0;
            mask_reg <= '0;
            itr_reg  <= '0;
        end else begin
            if (w_grant) r_rrPtr <= w_grantIdx;
            if (mask_wr) mask_reg <= mask_in;
            itr_reg <= (itr_reg & ~itr_clr) | w_grantVec;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : gCh
        chState_t r_state;
        chState_t w_nextState;

        assign w_req[g]      = (r_state == ST_IDLE) && !in_dev_hs[g];
        assign in_dev_ack[g] = (r_state != ST_ACK);

`ifdef IO_TIMEOUT_EN
        logic [TO_W-1:0] r_toCnt;
        logic            r_toErr;

        assign to_err[g] = r_toErr;
`endif

        // Returning to IDLE needs hs released, so a held request never captures twice
        always_comb begin
            w_nextState = r_state;
            case (r_state)
                ST_IDLE: if (w_grantVec[g]) w_nextState = ST_ACK;
                ST_ACK: begin
                    if (in_dev_hs[g]) w_nextState = ST_IDLE;
`ifdef IO_TIMEOUT_EN
                    else if (r_toCnt == TO_LAST) w_nextState = ST_TOUT;
`endif
                end
                ST_TOUT: if (in_dev_hs[g]) w_nextState = ST_IDLE;
                default: w_nextState = ST_IDLE;
            endcase
        end

        always_ff @(posedge g_clk) begin
            if (!g_clr) r_state <= ST_IDLE;
            else        r_state <= w_nextState;
        end

`ifdef IO_TIMEOUT_EN
        always_ff @(posedge g_clk) begin
            if (!g_clr) begin
                r_toCnt <= '0;
                r_toErr <= 1'b0;
            end else begin
                if (r_state == ST_ACK) r_toCnt <= r_toCnt + 1'b1;
                else                   r_toCnt <= '0;
                if ((r_state == ST_ACK) && (w_nextState == ST_TOUT)) r_toErr <= 1'b1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_io_in_ctrl.sv
// Self-checking bench for io_in_ctrl: a behavioural model predicts captures into a scoreboard queue,
// and a monitor compares FIFO pops and status outputs. Define IO_TIMEOUT_EN to cover the timeout path.
module tb_io_in_ctrl;

    localparam int DATA_W     = 8;
    localparam int NUM_CH     = 4;
    localparam int FIFO_DEPTH = 4;
`ifdef IO_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 15;
`endif

    logic                     g_clk = 1'b0;
    logic                     g_clr;
    logic [NUM_CH-1:0]        in_dev_hs;
    logic [NUM_CH*DATA_W-1:0] input_bus;
    logic [NUM_CH-1:0]        in_dev_ack;
    logic                     cpu_rd;
    logic [DATA_W-1:0]        cpu_data;
    logic [1:0]               cpu_ch;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [2:0]               fifo_count;
    logic                     mask_wr;
    logic [NUM_CH-1:0]        mask_in;
    logic [NUM_CH-1:0]        itr_clr;
    logic [NUM_CH-1:0]        mask_reg;
    logic [NUM_CH-1:0]        itr_reg;
    logic                     itr_pend;
`ifdef IO_TIMEOUT_EN
    logic [NUM_CH-1:0]        to_err;
`endif

    io_in_ctrl #(
        .DATA_W     (DATA_W),
        .NUM_CH     (NUM_CH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .g_clk      (g_clk),
        .g_clr      (g_clr),
        .in_dev_hs  (in_dev_hs),
        .input_bus  (input_bus),
        .in_dev_ack (in_dev_ack),
        .cpu_rd     (cpu_rd),
        .cpu_data   (cpu_data),
        .cpu_ch     (cpu_ch),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .mask_wr    (mask_wr),
        .mask_in    (mask_in),
        .itr_clr    (itr_clr),
        .mask_reg   (mask_reg),
        .itr_reg    (itr_reg),
        .itr_pend   (itr_pend)
`ifdef IO_TIMEOUT_EN
        ,
        .to_err     (to_err)
`endif
    );

    always #5 g_clk = ~g_clk;

    int nChecks = 0;
    int nFails  = 0;
    bit checkEn = 1'b0;

    // Reference model: busy = acknowledged and waiting for hs release; tout = gave up waiting
    bit                   mBusy [NUM_CH];
    bit                   mTout [NUM_CH];
    int                   mWait [NUM_CH];
    int                   mPtr;
    int                   mCount;
    logic [NUM_CH-1:0]    mItr;
    logic [NUM_CH-1:0]    mMask;
    logic [NUM_CH-1:0]    mToErr;
    logic [DATA_W+1:0]    expQ [$];

    logic [NUM_CH*DATA_W-1:0] curBus;
    logic [NUM_CH-1:0]        hsv;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [NUM_CH-1:0] expAck();
        logic [NUM_CH-1:0] a;
        a = '1;
        for (int c = 0; c < NUM_CH; c++) a[c] = !(mBusy[c] && !mTout[c]);
        return a;
    endfunction

    // Model advances on each rising edge from the inputs held stable since the previous edge
    always @(posedge g_clk) begin
        if (!g_clr) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mBusy[c] = 1'b0;
                mTout[c] = 1'b0;
                mWait[c] = 0;
            end
            mPtr   = 0;
            mCount = 0;
            mItr   = '0;
            mMask  = '0;
            mToErr = '0;
            expQ.delete();
        end else begin
            int gCh;
            logic [NUM_CH-1:0] newItr;
            gCh = -1;
            if (mCount < FIFO_DEPTH) begin
                for (int off = 1; off <= NUM_CH; off++) begin
                    int c;
                    c = (mPtr + off) % NUM_CH;
                    if (gCh < 0 && !mBusy[c] && in_dev_hs[c] == 1'b0) gCh = c;
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (mBusy[c]) begin
                    if (in_dev_hs[c]) begin
                        mBusy[c] = 1'b0;
                        mTout[c] = 1'b0;
                    end
`ifdef IO_TIMEOUT_EN
                    else if (!mTout[c]) begin
                        mWait[c]++;
                        if (mWait[c] == TIMEOUT_CYC) begin
                            mTout[c]  = 1'b1;
                            mToErr[c] = 1'b1;
                        end
                    end
`endif
                end
            end
            if (cpu_rd && mCount > 0) mCount--;
            newItr = mItr & ~itr_clr;
            if (gCh >= 0) begin
                mBusy[gCh] = 1'b1;
                mTout[gCh] = 1'b0;
                mWait[gCh] = 0;
                mCount++;
                mPtr = gCh;
                newItr[gCh] = 1'b1;
                expQ.push_back({gCh[1:0], input_bus[gCh*DATA_W +: DATA_W]});
            end
            mItr = newItr;
            if (mask_wr) mMask = mask_in;
        end
    end

    // Monitor: status every cycle, and a scoreboard pop whenever the CPU takes the FIFO head
    always @(negedge g_clk) begin
        if (checkEn) begin
            logic [DATA_W+1:0] e;
            checkOutput("in_dev_ack", in_dev_ack, expAck());
            checkOutput("fifo_count", fifo_count, mCount);
            checkOutput("fifo_empty", fifo_empty, mCount == 0);
            checkOutput("fifo_full", fifo_full, mCount == FIFO_DEPTH);
            checkOutput("itr_reg", itr_reg, mItr);
            checkOutput("mask_reg", mask_reg, mMask);
            checkOutput("itr_pend", itr_pend, |(mItr & mMask));
`ifdef IO_TIMEOUT_EN
            checkOutput("to_err", to_err, mToErr);
`endif
            if (g_clr && cpu_rd && !fifo_empty) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL head_pop: DUT presented ch %0d data %0h, expected no entry at %0t",
                             cpu_ch, cpu_data, $time);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("head_ch", cpu_ch, e[DATA_W+1:DATA_W]);
                    checkOutput("head_data", cpu_data, e[DATA_W-1:0]);
                end
            end
        end
    end

    task automatic applyStimulus(input logic clrN, input logic [NUM_CH-1:0] hs,
                                 input logic [NUM_CH*DATA_W-1:0] bus, input logic rd,
                                 input logic mwr, input logic [NUM_CH-1:0] min,
                                 input logic [NUM_CH-1:0] clr);
        g_clr     = clrN;
        in_dev_hs = hs;
        input_bus = bus;
        cpu_rd    = rd;
        mask_wr   = mwr;
        mask_in   = min;
        itr_clr   = clr;
        @(posedge g_clk);
        #1;
    endtask

    task automatic hsCycle(input logic [NUM_CH-1:0] hs, input logic rd);
        applyStimulus(1'b1, hs, curBus, rd, 1'b0, '0, '0);
    endtask

    initial begin
        curBus = '0;
        hsv    = '1;
        g_clr = 1'b0; in_dev_hs = '0; input_bus = '0; cpu_rd = 1'b0;
        mask_wr = 1'b0; mask_in = '0; itr_clr = '0;
        @(posedge g_clk);
        #1;
        checkEn = 1'b1;

        // Reset with every device requesting
        applyStimulus(1'b0, '0, curBus, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, curBus, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, '1, curBus, 1'b0, 1'b0, '0, '0);

        // Single capture on channel 2
        curBus = {8'h00, 8'h0A, 8'h00, 8'h00};
        repeat (3) hsCycle(4'b1011, 1'b0);
        repeat (2) hsCycle(4'b1111, 1'b0);
        hsCycle(4'b1111, 1'b1);

        // Capture on channel 3 leaves the round-robin pointer there
        curBus = {8'h33, 8'h00, 8'h00, 8'h00};
        repeat (2) hsCycle(4'b0111, 1'b0);
        hsCycle(4'b1111, 1'b0);
        hsCycle(4'b1111, 1'b1);

        // All channels at once, fill to full, ch0 re-requests and waits for a pop
        curBus = {8'h13, 8'h12, 8'h11, 8'h10};
        repeat (6) hsCycle(4'b0000, 1'b0);
        hsCycle(4'b0001, 1'b0);
        curBus[7:0] = 8'h14;
        repeat (3) hsCycle(4'b0000, 1'b0);
        hsCycle(4'b0000, 1'b1);
        hsCycle(4'b0000, 1'b0);
        repeat (7) hsCycle(4'b1111, 1'b1);

        // Interleaved writes and reads across the pointer wrap
        for (int i = 0; i < 6; i++) begin
            curBus[(i % NUM_CH)*DATA_W +: DATA_W] = DATA_W'(32'h20 + i);
            hsv = '1;
            hsv[i % NUM_CH] = 1'b0;
            hsCycle(hsv, i[0]);
            hsCycle(4'b1111, i >= 2);
        end
        repeat (5) hsCycle(4'b1111, 1'b1);

        // Interrupt masking, and set winning over clear on the same edge
        applyStimulus(1'b1, 4'b1111, curBus, 1'b0, 1'b1, 4'b0010, '0);
        curBus[15:8] = 8'h51;
        hsCycle(4'b1101, 1'b0);
        hsCycle(4'b1111, 1'b0);
        curBus[15:8] = 8'h52;
        applyStimulus(1'b1, 4'b1101, curBus, 1'b0, 1'b0, '0, 4'b0010);
        hsCycle(4'b1111, 1'b0);
        applyStimulus(1'b1, 4'b1111, curBus, 1'b1, 1'b1, 4'b0000, '0);
        repeat (2) hsCycle(4'b1111, 1'b1);
        applyStimulus(1'b1, 4'b1111, curBus, 1'b0, 1'b0, '0, 4'b1111);

`ifdef IO_TIMEOUT_EN
        // Held request times out and is not recaptured until it toggles
        curBus[31:24] = 8'h66;
        repeat (20) hsCycle(4'b0111, 1'b0);
        hsCycle(4'b1111, 1'b1);
        curBus[31:24] = 8'h67;
        hsCycle(4'b0111, 1'b0);
        repeat (2) hsCycle(4'b1111, 1'b1);
`endif

        // Randomised devices, CPU reads, mask writes, clears and occasional resets
        hsv = '1;
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(3) == 0) hsv[c] = ~hsv[c];
            curBus = $urandom;
            applyStimulus($urandom_range(150) != 0, hsv, curBus, $urandom_range(2) == 0,
                          $urandom_range(15) == 0, NUM_CH'($urandom),
                          ($urandom_range(7) == 0) ? NUM_CH'($urandom) : '0);
        end
        repeat (6) hsCycle(4'b1111, 1'b1);

        @(negedge g_clk);
        #1;
        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
